// File: rtl/fwuart_pkg.sv
// Shared UART timing constants used by the clock generator, receiver and receive FIFO.
package fwuart_pkg;

  localparam int unsigned FWUART_TICKS_PER_BIT  = 16;
  localparam int unsigned FWUART_BITS_PER_CHAR  = 10;
  localparam int unsigned FWUART_TICKS_PER_CHAR = FWUART_TICKS_PER_BIT * FWUART_BITS_PER_CHAR;

endpackage

// File: rtl/fwuart_rx_timeout.sv
// Receive idle timer: counts clock_x16 strobes while bytes sit untouched in the FIFO.
module fwuart_rx_timeout
  import fwuart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_x16,
  input  logic activity,
  input  logic empty,
  output logic timeout
);

  localparam int unsigned LIMIT = TIMEOUT_CHARS * FWUART_TICKS_PER_CHAR;
  localparam int unsigned CW    = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturating counter, held at zero while there is traffic or nothing buffered
  always_comb begin
    count_d = count_q;
    if (activity || empty) begin
      count_d = '0;
    end else if (clock_x16 && (count_q != CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (count_q == CW'(LIMIT));

endmodule

// File: rtl/fwuart_rx_fifo.sv
// Receive byte FIFO (first-word-fall-through) that never stalls the receiver; drops on overflow
// and raises irq on fill threshold, idle timeout or overrun.
module fwuart_rx_fifo
  import fwuart_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned THRESHOLD     = 8,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clock_x16,
  input  logic [7:0]                 t_data,
  input  logic                       t_valid,
  output logic                       t_ready,
  output logic [7:0]                 i_data,
  output logic                       i_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic                       irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          overrun_q;
  logic          overrun_d;
  logic          irq_q;
  logic          irq_d;
  logic          push_req;
  logic          pop;
  logic          room;
  logic          push;
  logic          drop;
  logic          timeout;

  assign t_ready  = 1'b1;
  assign push_req = t_valid && t_ready;
  assign pop      = i_valid && i_ready;
  // A pop in the same cycle frees the slot the incoming byte needs
  assign room     = (level_q != LW'(DEPTH)) || pop;
  assign push     = push_req && room;
  assign drop     = push_req && !room;

  always_comb begin
    level_d   = level_q;
    overrun_d = overrun_q;
    irq_d     = (level_q >= LW'(THRESHOLD)) || timeout || overrun_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr_q] <= t_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q   <= level_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  fwuart_rx_timeout #(
    .TIMEOUT_CHARS(TIMEOUT_CHARS)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clock_x16(clock_x16),
    .activity (push_req || pop),
    .empty    (level_q == '0),
    .timeout  (timeout)
  );

  assign i_data  = mem[rd_ptr_q];
  assign i_valid = (level_q != '0);
  assign level   = level_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_fwuart_rx_fifo.sv
// Scoreboard bench for fwuart_rx_fifo: expected bytes queued on push, compared on pop.
module tb_fwuart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned THR   = 8;
  localparam int unsigned LIMIT = 4 * 160;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clock_x16 = 1'b0;
  logic [7:0] t_data = '0;
  logic       t_valid = 1'b0;
  logic       t_ready;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready = 1'b0;
  logic [4:0] level;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       irq;

  int         n_tests = 0;
  int         n_fail  = 0;

  logic [7:0] sb [$];
  int         m_level = 0;
  bit         m_ovr   = 1'b0;
  int         m_cnt   = 0;
  bit         m_irq   = 1'b0;
  logic [7:0] last_pop;

  fwuart_rx_fifo #(
    .DEPTH(DEPTH), .THRESHOLD(THR), .TIMEOUT_CHARS(4)
  ) dut (
    .clock(clock), .reset(reset), .clock_x16(clock_x16),
    .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .level(level), .overrun(overrun), .clr_overrun(clr_overrun), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model advances alongside and outputs are checked after the edge
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy,
                     input bit x16 = 1'b0, input bit clr = 1'b0);
    bit pop, room, act, wr;
    t_valid = v; t_data = d; i_ready = rdy; clock_x16 = x16; clr_overrun = clr;
    chk("i_valid", 32'(i_valid), 32'(m_level != 0));
    pop = rdy && (m_level != 0);
    if (pop) begin
      last_pop = sb.pop_front();
      chk("i_data", 32'(i_data), 32'(last_pop));
    end
    room  = (m_level < DEPTH) || pop;
    wr    = v && room;
    act   = v || pop;
    m_irq = (m_level >= THR) || (m_cnt == LIMIT) || m_ovr;
    if (act || m_level == 0) m_cnt = 0;
    else if (x16 && m_cnt != LIMIT) m_cnt++;
    if (wr) sb.push_back(d);
    if (v && !room) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (wr && !pop) m_level++;
    else if (pop && !wr) m_level--;
    @(posedge clock); #1;
    t_valid = 1'b0; i_ready = 1'b0; clock_x16 = 1'b0; clr_overrun = 1'b0;
    chk("level", 32'(level), 32'(m_level));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_level != 0; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ivalid", 32'(i_valid), 32'd0);
    chk("rst_idata", 32'(i_data), 32'd0);
    chk("rst_tready", 32'(t_ready), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Single byte, held then popped
    cyc(1'b1, 8'hA5, 1'b0);
    chk("a5_data", 32'(i_data), 32'hA5);
    chk("a5_valid", 32'(i_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("a5_empty", 32'(i_valid), 32'd0);

    // Threshold: fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 7) chk("thr_lag", 32'(irq), 32'd0);
    end
    chk("thr_irq", 32'(irq), 32'd1);

    // Overrun while full, then clear
    cyc(1'b1, 8'h55, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_level", 32'(level), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous push/pop while full
    cyc(1'b1, 8'h77, 1'b1);
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_ovr", 32'(overrun), 32'd0);
    drain();
    chk("pp_last", 32'(last_pop), 32'h77);
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_irq", 32'(irq), 32'd0);

    // Idle timeout with one byte held; strobe every cycle
    cyc(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < int'(LIMIT); i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_pre", 32'(irq), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_irq", 32'(irq), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("to_clr", 32'(irq), 32'd0);

    // Wrap-around with random consumer
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation with 5 bytes stored
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_ivalid", 32'(i_valid), 32'd0);
    chk("mr_ovr", 32'(overrun), 32'd0);
    chk("mr_irq", 32'(irq), 32'd0);
    chk("mr_idata", 32'(i_data), 32'd0);
    sb.delete(); m_level = 0; m_ovr = 1'b0; m_cnt = 0; m_irq = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwuart_rx_fifo.md
# fwuart_rx_fifo

Receive-side byte buffer placed directly downstream of `fwuart_rx`. It accepts every byte the receiver produces on its ready/valid initiator port, stores up to DEPTH bytes and presents them first-word-fall-through to the host-side consumer. It also raises an interrupt on fill threshold, on a receive idle timeout counted in `clock_x16` ticks, or on overrun. A serial line cannot be stalled, so the block never back-pressures the receiver and drops bytes on overflow.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- THRESHOLD, 8, level at or above which the fill-threshold interrupt asserts; range 1..DEPTH
- TIMEOUT_CHARS, 4, idle time before the timeout interrupt, in character times (1 char = 160 `clock_x16` ticks)

Ports:
- clock  in  1  system clock; sole clock domain
- reset  in  1  asynchronous, active-low reset
- clock_x16  in  1  single-cycle enable strobe at 16× baud, synchronous to `clock` (from `fwuart_clkgen`)
- t_data  in  8  received byte from `fwuart_rx`
- t_valid  in  1  byte present
- t_ready  out  1  constant 1 out of reset
- i_data  out  8  head-of-FIFO byte
- i_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts head byte
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky flag: a byte was dropped
- clr_overrun  in  1  single-cycle pulse that clears `overrun`
- irq  out  1  interrupt request

## Operation
- Push: `t_valid && t_ready`. If there is room after this cycle's pop, write at `wr_ptr` and advance it. Otherwise drop the byte and set `overrun`.
- Pop: `i_valid && i_ready`. Advance `rd_ptr`.
- `i_data = mem[rd_ptr]` (combinational read). `i_valid = (level != 0)`.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. `level` is tracked explicitly: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push with pop while full: both take effect, no overrun, `level` stays at DEPTH.
- Push while empty: the byte is not visible until the next cycle, so no same-cycle pop.
- `overrun`: set on a dropped byte; cleared by `clr_overrun`. Set wins when both occur in the same cycle.
- Idle timer, counter width fits TIMEOUT_CHARS*160:
  - Cleared on any push, any pop, or when `level == 0`.
  - Otherwise increments on each `clock_x16` strobe, saturating at TIMEOUT_CHARS*160.
  - `timeout` = counter at saturation.
- `irq = (level >= THRESHOLD) | timeout | overrun`, registered.

## Timing
- Reset (async assert, sync release): pointers, `level`, timer, `overrun`, `irq` all 0; memory cleared, so `i_data` = 0. `i_valid` = 0, `t_ready` = 1.
- Push to `i_valid` high: 1 cycle. Push to `level` update: 1 cycle.
- `irq` follows its conditions by 1 cycle.
- `timeout` asserts on the cycle after the TIMEOUT_CHARS*160-th strobe since the last activity.
- Reset asserted mid-operation: all contents are discarded immediately; no partial state survives.

## Structure
- Shared `fwuart_pkg` holds `FWUART_TICKS_PER_BIT` = 16, `FWUART_BITS_PER_CHAR` = 10 and the derived `FWUART_TICKS_PER_CHAR` = 160. `fwuart_clkgen` and `fwuart_rx` use the same constants.
- One sub-module, `fwuart_rx_timeout`, contains the idle counter. Inputs: `clock`, `reset`, `clock_x16`, `activity`, `empty`. Output: `timeout`.
- Memory is a register array local to `fwuart_rx_fifo`.
- Instantiated in the back-to-back bench between `fwuart_rx`'s initiator port and a consumer model.

## Test plan
- Single byte 0xA5 pushed, `i_ready` = 0 → next cycle `i_valid` = 1, `i_data` = 0xA5, `level` = 1. Then `i_ready` = 1 for one cycle → `level` = 0, `i_valid` = 0.
- Push 0x00..0x0F with DEPTH = 16, THRESHOLD = 8 → `irq` rises the cycle after `level` reaches 8. Drain yields 0x00..0x0F in order; `irq` clears below 8.
- Fill to 16, push 0x55 with `i_ready` = 0 → byte dropped, `overrun` = 1, `level` = 16. `clr_overrun` → `overrun` = 0.
- Full, then simultaneous push 0x77 and pop → no overrun, `level` = 16, and 0x77 emerges last when drained.
- One byte held, no traffic, TIMEOUT_CHARS = 4 → `irq` asserts after 640 `clock_x16` strobes (+1 cycle). A pop clears the timer and `irq`. Check wrap-around by pushing/popping 40 bytes with random `i_ready`.
- Assert reset with 5 bytes stored → `level` = 0, `i_valid` = 0, `overrun` = 0, `irq` = 0 immediately (before the next clock edge).
